// File: rtl/user_clk_glitch_mux_pkg.sv
`timescale 1ns/1ps
// user_clk_glitch_mux_pkg: source encodings, synchroniser edge select and default depth
package user_clk_glitch_mux_pkg;
    localparam logic SEL_CLK1 = 1'b0;
    localparam logic SEL_CLK2 = 1'b1;
    localparam int SYNC_STAGES_DEF = 2;
    typedef enum logic {EDGE_RISE = 1'b0, EDGE_FALL = 1'b1} edge_e;
endpackage

// File: rtl/user_clk_glitch_mux_clk_mux_sync.sv
`timescale 1ns/1ps
// clk_mux_sync: N-stage synchroniser with async active-low clear and selectable clock edge
module clk_mux_sync
    import user_clk_glitch_mux_pkg::*;
#(
    parameter int    STAGES  = SYNC_STAGES_DEF,
    parameter edge_e EDGE    = EDGE_RISE,
    parameter logic  RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;
    generate
        if (EDGE == EDGE_FALL) begin : g_fall
            // shift chain on the falling edge so the output only moves while the clock is low
            always_ff @(negedge i_clk or negedge i_rst_n)
                if (!i_rst_n) r_sync <= {STAGES{RST_VAL}};
                else r_sync <= {r_sync[STAGES-2:0], i_d};
        end else begin : g_rise
            // shift chain on the rising edge
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) r_sync <= {STAGES{RST_VAL}};
                else r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    endgenerate
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/user_clk_glitch_mux.sv
`timescale 1ns/1ps
// user_clk_glitch_mux: glitch-free 2:1 clock mux with cross-coupled enable handshake
module user_clk_glitch_mux
    import user_clk_glitch_mux_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic DEFAULT_SEL = SEL_CLK1
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic aclk_in1,
    input  logic aclk_in2,
    input  logic selection,
    output logic aclk_out,
    output logic active_sel,
    output logic busy
);
    logic w_sel_q, w_req1, w_req2, w_en1, w_en2, w_st1, w_st2, w_gate1, w_gate2;
    logic r_active_sel;
    clk_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(EDGE_RISE), .RST_VAL(DEFAULT_SEL)) u_sel_sync (
        .i_clk(aclk), .i_rst_n(aresetn), .i_d(selection), .o_q(w_sel_q));
    assign w_req1 = (w_sel_q == SEL_CLK1) & ~w_en2;
    assign w_req2 = (w_sel_q == SEL_CLK2) & ~w_en1;
    clk_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(EDGE_FALL), .RST_VAL(1'b0)) u_en1_sync (
        .i_clk(aclk_in1), .i_rst_n(aresetn), .i_d(w_req1), .o_q(w_en1));
    clk_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(EDGE_FALL), .RST_VAL(1'b0)) u_en2_sync (
        .i_clk(aclk_in2), .i_rst_n(aresetn), .i_d(w_req2), .o_q(w_en2));
    clk_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(EDGE_RISE), .RST_VAL(1'b0)) u_st1_sync (
        .i_clk(aclk), .i_rst_n(aresetn), .i_d(w_en1), .o_q(w_st1));
    clk_mux_sync #(.STAGES(SYNC_STAGES), .EDGE(EDGE_RISE), .RST_VAL(1'b0)) u_st2_sync (
        .i_clk(aclk), .i_rst_n(aresetn), .i_d(w_en2), .o_q(w_st2));
    // Plain AND/OR output gating; enables only move while their source is low
    assign w_gate1  = aclk_in1 & w_en1;
    assign w_gate2  = aclk_in2 & w_en2;
    assign aclk_out = w_gate1 | w_gate2;
    // Track which source drives the output; hold through the both-off gap
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) r_active_sel <= DEFAULT_SEL;
        else if (w_st1 ^ w_st2) r_active_sel <= w_st2;
    assign active_sel = r_active_sel;
    assign busy = ~((w_sel_q == SEL_CLK2) ? (w_st2 & ~w_st1) : (w_st1 & ~w_st2));
endmodule

// File: tb/tb_user_clk_glitch_mux.sv
`timescale 1ns/1ps
// tb_user_clk_glitch_mux: table, random and corner-case checks of the glitch-free clock mux
module tb_user_clk_glitch_mux;
    import user_clk_glitch_mux_pkg::*;
    typedef struct {
        logic sel;
        logic exp_active;
        logic exp_busy;
        int   exp_pulses;
    } vec_t;
    logic aclk = 1'b0, aresetn = 1'b1, aclk_in1 = 1'b0, aclk_in2 = 1'b0, selection = 1'b0;
    logic aclk_out, active_sel, busy;
    int errors = 0, checks = 0, pulses = 0;
    bit run1 = 1'b1, glitch_en = 1'b0;
    logic busy_prev = 1'b1;
    realtime last_t = 0.0;
    vec_t tbl[8];
    logic q[$];
    logic exp_sel;

    user_clk_glitch_mux #(.SYNC_STAGES(2), .DEFAULT_SEL(SEL_CLK1)) dut (
        .aclk(aclk), .aresetn(aresetn), .aclk_in1(aclk_in1), .aclk_in2(aclk_in2),
        .selection(selection), .aclk_out(aclk_out), .active_sel(active_sel), .busy(busy));

    // 100 MHz control clock
    always #5 aclk = ~aclk;
    // 50 MHz source 1, can be parked low
    always begin
        #10;
        aclk_in1 = run1 ? ~aclk_in1 : 1'b0;
    end
    // 75 MHz source 2
    always #6.67 aclk_in2 = ~aclk_in2;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output must equal the chosen source just after each of its edges
    task automatic track(input logic src, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            if (src) @(aclk_in2);
            else @(aclk_in1);
            #0.1;
            chk(name, aclk_out, src ? aclk_in2 : aclk_in1);
        end
    endtask

    // Every output phase must be at least the shorter source half-period
    always @(aclk_out) begin
        if (glitch_en) begin
            checks++;
            if ($realtime - last_t < 6.6) begin
                errors++;
                $display("FAIL glitch: phase %0.3f ns shorter than 6.6 ns at %0t", $realtime - last_t, $time);
            end
        end
        last_t = $realtime;
    end

    // Count rising edges of busy as seen in the control domain
    always @(negedge aclk) begin
        if (busy && !busy_prev) pulses++;
        busy_prev = busy;
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 0};

        #1 aresetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #23;
            chk("rst_out", aclk_out, 1'b0);
            chk("rst_busy", busy, 1'b1);
            chk("rst_active", active_sel, 1'b0);
        end
        #8 aresetn = 1'b1;
        last_t = $realtime;
        glitch_en = 1'b1;
        repeat (2) @(negedge aclk_in1);
        #0.1;
        track(1'b0, 6, "start_track");
        #100;
        chk("start_active", active_sel, 1'b0);
        chk("start_busy", busy, 1'b0);

        for (int i = 0; i < 8; i++) begin
            pulses = 0;
            selection = tbl[i].sel;
            #1000;
            chk("tbl_active", active_sel, tbl[i].exp_active);
            chk("tbl_busy", busy, tbl[i].exp_busy);
            chk_int("tbl_pulses", pulses, tbl[i].exp_pulses);
            track(tbl[i].exp_active, 6, "tbl_track");
        end

        for (int r = 0; r < 10; r++) begin
            q.delete();
            for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                q.push_back(1'($urandom_range(0, 1)));
                selection = q[$];
                #($urandom_range(1, 60));
            end
            exp_sel = q[$];
            #400;
            chk("rnd_active", active_sel, exp_sel);
            chk("rnd_busy", busy, 1'b0);
            track(exp_sel, 4, "rnd_track");
        end

        selection = 1'b0;
        #400;
        selection = 1'b1;
        #2 selection = 1'b0;
        #400;
        chk("blip_active", active_sel, 1'b0);
        chk("blip_busy", busy, 1'b0);
        track(1'b0, 4, "blip_track");

        @(negedge aclk_in1);
        run1 = 1'b0;
        selection = 1'b1;
        #100;
        for (int i = 0; i < 5; i++) begin
            #37;
            chk("stall_out", aclk_out, 1'b0);
            chk("stall_busy", busy, 1'b1);
        end
        chk("stall_active", active_sel, 1'b0);
        run1 = 1'b1;
        #400;
        chk("resume_active", active_sel, 1'b1);
        chk("resume_busy", busy, 1'b0);
        track(1'b1, 6, "resume_track");

        selection = 1'b0;
        #40;
        glitch_en = 1'b0;
        aresetn = 1'b0;
        #0.1;
        chk("midrst_out", aclk_out, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #19;
            chk("midrst_hold", aclk_out, 1'b0);
        end
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_active", active_sel, 1'b0);
        @(posedge aclk_in1);
        #3 aresetn = 1'b1;
        last_t = $realtime;
        glitch_en = 1'b1;
        repeat (2) @(negedge aclk_in1);
        #0.1;
        track(1'b0, 6, "midrst_track");
        #200;
        chk("midrst_end_active", active_sel, 1'b0);
        chk("midrst_end_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
